inst_rom_loader: RTL and testbench

Instruction-side responder for the CPU core's fetch port (`rom_ce`/`rom_addr`/`rom_data`). It holds the instruction image in on-chip storage and serves fetches combinationally, because the core's IF/ID register samples `rom_data` at the same edge. The image is loaded through a byte-wide valid/ready stream. The block holds the core in reset until loading completes, and a reload request returns it to the loading state.

---
 rtl/inst_rom_loader_pkg.sv | 20 ++
 rtl/inst_mem_array.sv | 25 ++
 rtl/inst_rom_loader.sv | 126 ++++++++++++
 tb/tb_inst_rom_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader.
// RegBus/InstAddrBus/InstBus are the core's 32-bit data, fetch-address and
// instruction buses; LdByteBus is the byte-wide load stream; ZeroWord is the
// value the core executes as NOP. state_e encodes the loader FSM.
package inst_rom_loader_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;
    typedef logic [7:0]  LdByteBus;

    localparam InstBus ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: DEPTH x 32 words, one synchronous write port and one
// asynchronous read port. Contents are never reset.
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr -> o_rdata read port.
module inst_mem_array
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  InstBus                i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output InstBus                o_rdata
);

    InstBus r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-side responder for the core's fetch port. Loads an image from a
// byte stream (big-endian word assembly), holds the core in reset until the
// last byte is accepted, then serves fetches combinationally.
// Ports: clk, rst (async, active-high); rom_ce_i/rom_addr_i -> rom_data_o fetch;
// ld_valid_i/ld_byte_i/ld_last_i/ld_ready_o load stream; ld_reload_i restart;
// cpu_rst_o core reset; load_done_o image loaded; ld_err_o sticky overflow.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rom_ce_i,
    input  InstAddrBus rom_addr_i,
    output InstBus     rom_data_o,
    input  logic       ld_valid_i,
    input  LdByteBus   ld_byte_i,
    input  logic       ld_last_i,
    output logic       ld_ready_o,
    input  logic       ld_reload_i,
    output logic       cpu_rst_o,
    output logic       load_done_o,
    output logic       ld_err_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e              r_state, w_next;
    logic                r_cpu_rst, r_ld_ready, r_load_done, r_err;
    logic [1:0]          r_bcnt;
    InstBus              r_asm;
    logic [ADDR_WIDTH:0] r_wptr;

    logic                  w_accept, w_word_done, w_full, w_we, w_reload, w_rd_ok;
    InstBus                w_word, w_rdata;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_unused_addr;

    assign w_accept    = ld_valid_i & r_ld_ready;
    assign w_word_done = ld_last_i | (r_bcnt == 2'd3);
    assign w_full      = (r_wptr == DEPTH);
    assign w_we        = w_accept & w_word_done & ~w_full;
    assign w_reload    = (r_state == ST_RUN) & ld_reload_i;

    // Earlier bytes already sit in their lanes with zeros below, so OR-ing in
    // the new byte also yields the zero-padded partial word on ld_last_i.
    assign w_word = r_asm | ({ld_byte_i, 24'h0} >> {r_bcnt, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: w_next = ST_LOAD;
            ST_LOAD: if (w_accept && ld_last_i) w_next = ST_RUN;
            ST_RUN:  if (ld_reload_i) w_next = ST_LOAD;
            default: w_next = ST_INIT;
        endcase
    end

    // Outputs are registered from the next-state decode so they come straight
    // off flops and never glitch on multi-bit state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rst   <= 1'b1;
            r_ld_ready  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_cpu_rst   <= (w_next != ST_RUN);
            r_ld_ready  <= (w_next == ST_LOAD);
            r_load_done <= (w_next == ST_RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt <= 2'd0;
            r_asm  <= ZeroWord;
            r_wptr <= '0;
            r_err  <= 1'b0;
        end else if (w_reload) begin
            r_bcnt <= 2'd0;
            r_asm  <= ZeroWord;
            r_wptr <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            if (w_word_done) begin
                r_bcnt <= 2'd0;
                r_asm  <= ZeroWord;
                // wptr saturates at DEPTH; further words are dropped and flagged.
                if (w_full) r_err  <= 1'b1;
                else        r_wptr <= r_wptr + 1'b1;
            end else begin
                r_bcnt <= r_bcnt + 2'd1;
                r_asm  <= w_word;
            end
        end
    end

    inst_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (w_word),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // Fetch only returns loaded words: outside the array or past wptr reads NOP.
    assign w_idx   = rom_addr_i[ADDR_WIDTH+1:2];
    assign w_rd_ok = rom_ce_i && (r_state == ST_RUN)
                     && ((rom_addr_i >> (ADDR_WIDTH + 2)) == 32'd0)
                     && ({1'b0, w_idx} < r_wptr);
    assign w_unused_addr = ^rom_addr_i[1:0];

    assign rom_data_o  = w_rd_ok ? w_rdata : ZeroWord;
    assign ld_ready_o  = r_ld_ready;
    assign cpu_rst_o   = r_cpu_rst;
    assign load_done_o = r_load_done;
    assign ld_err_o    = r_err;

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_last_i;
    logic        ld_reload_i;

    logic [31:0] a_data, s_data;
    logic        a_ready, a_cpu_rst, a_done, a_err;
    logic        s_ready, s_cpu_rst, s_done, s_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Default-size instance and a 4-word instance for overflow; both see the same stimulus.
    inst_rom_loader #(.ADDR_WIDTH(10)) u_dut (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
        .rom_data_o(a_data), .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i),
        .ld_last_i(ld_last_i), .ld_ready_o(a_ready), .ld_reload_i(ld_reload_i),
        .cpu_rst_o(a_cpu_rst), .load_done_o(a_done), .ld_err_o(a_err)
    );

    inst_rom_loader #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
        .rom_data_o(s_data), .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i),
        .ld_last_i(ld_last_i), .ld_ready_o(s_ready), .ld_reload_i(ld_reload_i),
        .cpu_rst_o(s_cpu_rst), .load_done_o(s_done), .ld_err_o(s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        ld_last_i  = last;
        tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic fetch(input logic ce, input logic [31:0] addr);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1;
    endtask

    task automatic pulse_reload();
        ld_reload_i = 1'b1;
        tick();
        ld_reload_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rom_ce_i = 1'b1; rom_addr_i = 32'h0;
        ld_valid_i = 1'b0; ld_byte_i = 8'h0; ld_last_i = 1'b0; ld_reload_i = 1'b0;
        tick(); tick();
        tests++; if ({a_cpu_rst, a_ready, a_done, a_err} !== 4'b1000) begin
            fails++; $display("FAIL reset_outs got %b want 1000", {a_cpu_rst, a_ready, a_done, a_err}); end
        tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", a_data); end
        rst = 1'b0;
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL init_ready got %b want 0", a_ready); end
        tick();
        tests++; if (a_ready !== 1'b1 || a_cpu_rst !== 1'b1) begin
            fails++; $display("FAIL load_entry ready=%b cpu_rst=%b want 1 1", a_ready, a_cpu_rst); end
    endtask

    task automatic test_first_load();
        send_byte(8'h34, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        tests++; if (a_cpu_rst !== 1'b1) begin fails++; $display("FAIL cpu_rst_held got %b want 1", a_cpu_rst); end
        send_byte(8'h05, 1'b1);
        tests++; if ({a_cpu_rst, a_ready, a_done} !== 3'b001) begin
            fails++; $display("FAIL run_entry got %b want 001", {a_cpu_rst, a_ready, a_done}); end
        fetch(1'b1, 32'h0);
        tests++; if (a_data !== 32'h34010005) begin fails++; $display("FAIL first_word got %h want 34010005", a_data); end
        fetch(1'b1, 32'h3);
        tests++; if (a_data !== 32'h34010005) begin fails++; $display("FAIL low_bits_ignored got %h want 34010005", a_data); end
        fetch(1'b1, 32'h4);
        tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL past_wptr got %h want 0", a_data); end
    endtask

    task automatic test_gating();
        fetch(1'b0, 32'h0);
        tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL ce_low got %h want 0", a_data); end
        fetch(1'b1, 32'h0000_1000);
        tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL high_addr got %h want 0", a_data); end
        // A byte offered in RUN must not be taken: still running, image unchanged.
        ld_valid_i = 1'b1; ld_byte_i = 8'hFF; ld_last_i = 1'b1;
        tick();
        ld_valid_i = 1'b0; ld_last_i = 1'b0;
        fetch(1'b1, 32'h0);
        tests++; if (a_done !== 1'b1 || a_data !== 32'h34010005) begin
            fails++; $display("FAIL run_valid_ignored done=%b data=%h want 1 34010005", a_done, a_data); end
        pulse_reload();
        tests++; if (a_cpu_rst !== 1'b1 || a_ready !== 1'b1) begin
            fails++; $display("FAIL reload_edge cpu_rst=%b ready=%b want 1 1", a_cpu_rst, a_ready); end
        fetch(1'b1, 32'h0);
        tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL load_gated got %h want 0", a_data); end
    endtask

    task automatic test_partial_last();
        logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) send_byte(bytes[i], i == 5);
        fetch(1'b1, 32'h0);
        tests++; if (a_data !== 32'h11223344) begin fails++; $display("FAIL partial_w0 got %h want 11223344", a_data); end
        fetch(1'b1, 32'h4);
        tests++; if (a_data !== 32'h55660000) begin fails++; $display("FAIL partial_w1 got %h want 55660000", a_data); end
        fetch(1'b1, 32'h8);
        tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL partial_w2 got %h want 0", a_data); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp [5] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
        pulse_reload();
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1), i == 19);
        tests++; if (s_err !== 1'b1 || a_err !== 1'b0) begin
            fails++; $display("FAIL ovf_err small=%b big=%b want 1 0", s_err, a_err); end
        for (int w = 0; w < 4; w++) begin
            fetch(1'b1, 32'(w * 4));
            tests++; if (s_data !== exp[w]) begin fails++; $display("FAIL ovf_word%0d got %h want %h", w, s_data, exp[w]); end
        end
        fetch(1'b1, 32'h10);
        tests++; if (s_data !== 32'h0 || a_data !== exp[4]) begin
            fails++; $display("FAIL ovf_word4 small=%h big=%h want 0 %h", s_data, a_data, exp[4]); end
        tick(); tick(); tick();
        tests++; if (s_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", s_err); end
    endtask

    task automatic test_reload();
        ld_reload_i = 1'b1;
        tick();
        ld_reload_i = 1'b0;
        tests++; if (s_cpu_rst !== 1'b1 || s_err !== 1'b0 || s_done !== 1'b0) begin
            fails++; $display("FAIL reload_clear cpu_rst=%b err=%b done=%b want 1 0 0", s_cpu_rst, s_err, s_done); end
        for (int i = 0; i < 4; i++) send_byte(8'hAA, i == 3);
        fetch(1'b1, 32'h4);
        tests++; if (a_data !== 32'h0 || s_data !== 32'h0) begin
            fails++; $display("FAIL reload_w1 big=%h small=%h want 0 0", a_data, s_data); end
        fetch(1'b1, 32'h0);
        tests++; if (a_data !== 32'hAAAAAAAA || s_data !== 32'hAAAAAAAA) begin
            fails++; $display("FAIL reload_w0 big=%h small=%h want aaaaaaaa", a_data, s_data); end
    endtask

    task automatic test_rst_mid_load();
        logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pulse_reload();
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        rst = 1'b1;
        #1;
        tests++; if (a_ready !== 1'b0 || a_cpu_rst !== 1'b1) begin
            fails++; $display("FAIL mid_rst_async ready=%b cpu_rst=%b want 0 1", a_ready, a_cpu_rst); end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_byte(bytes[i], i == 3);
        fetch(1'b1, 32'h0);
        tests++; if (a_data !== 32'hDEADBEEF) begin fails++; $display("FAIL mid_rst_w0 got %h want deadbeef", a_data); end
        fetch(1'b1, 32'h4);
        tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL mid_rst_w1 got %h want 0", a_data); end
        tests++; if (a_done !== 1'b1 || a_err !== 1'b0) begin
            fails++; $display("FAIL mid_rst_state done=%b err=%b want 1 0", a_done, a_err); end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_gating();
        test_partial_last();
        test_overflow();
        test_reload();
        test_rst_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
